// File: rtl/ysyx_25030085_pkg.sv
// Shared types and encodings for the ysyx_25030085 decode stage.
// Optional RV32M bundle fields are built when IDU_RV32M_EN is defined.
package ysyx_25030085_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0, ALU_SLL = 4'h1, ALU_SLT = 4'h2,
      ALU_SLTU = 4'h3, ALU_XOR = 4'h4, ALU_SRA = 4'h5,
      ALU_SRL  = 4'h6, ALU_OR  = 4'h7, ALU_AND = 4'h8,
      ALU_PCI  = 4'h9, ALU_SUB = 4'hA
   } alu_op_e;

   typedef enum logic [2:0] {
      MEM_B = 3'd0, MEM_H = 3'd1, MEM_W = 3'd2,
      MEM_BU = 3'd4, MEM_HU = 3'd5
   } mem_op_e;

   typedef enum logic [2:0] {
      WB_ALU = 3'd0, WB_MEM = 3'd1, WB_PC4 = 3'd2,
      WB_IMM = 3'd3, WB_CSR = 3'd4
   } wb_sel_e;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0, BR_BEQ = 3'd1, BR_BNE = 3'd2,
      BR_BLT = 3'd3, BR_BGE = 3'd4, BR_BLTU = 3'd5,
      BR_BGEU = 3'd6
   } br_type_e;

   typedef enum logic [1:0] {
      JMP_NONE = 2'b00, JMP_JAL = 2'b01, JMP_JALR = 2'b10
   } jump_e;

   typedef enum logic [1:0] {
      CSR_NONE = 2'd0, CSR_W = 2'd1, CSR_S = 2'd2
   } csr_op_e;

   typedef enum logic [2:0] {
      SYS_NONE = 3'd0, SYS_ECALL = 3'd1, SYS_EBREAK = 3'd2,
      SYS_MRET = 3'd3, SYS_ILL = 3'd4
   } sys_e;

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} idu_state_e;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [XLEN_DEF-1:0] imm;
      alu_op_e             alu_op;
      logic                alu_src;
      logic                mem_ren;
      logic                mem_wen;
      mem_op_e             mem_op;
      wb_sel_e             wb_sel;
      logic                reg_wen;
      br_type_e            br_type;
      jump_e               jump;
      csr_op_e             csr_op;
      logic [11:0]         csr_addr;
      sys_e                sys;
`ifdef IDU_RV32M_EN
      logic                mdu_en;
      logic [2:0]          mdu_op;
`endif
   } id_ex_t;

   function automatic logic [31:0] imm_i(input logic [31:0] i);
      return {{20{i[31]}}, i[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] i);
      return {{20{i[31]}}, i[31:25], i[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] i);
      return {i[31:12], 12'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/ysyx_25030085_idu_dec.sv
// Combinational RV32I(+M) decoder: {pc, inst} -> id_ex_t bundle.
// The M encodings are legal only when IDU_RV32M_EN is defined.
module ysyx_25030085_idu_dec
   import ysyx_25030085_pkg::*;
#(
   parameter logic [31:0] PC_BASE = 32'h8000_0000
) (
   input  logic [31:0] pc,
   input  logic [31:0] inst,
   output id_ex_t      dec
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [11:0] imm12;
   logic [31:0] shamt;
   logic        ill;
   id_ex_t      d;

   assign opc   = inst[6:0];
   assign f3    = inst[14:12];
   assign f7    = inst[31:25];
   assign rd    = inst[11:7];
   assign rs1   = inst[19:15];
   assign rs2   = inst[24:20];
   assign imm12 = inst[31:20];
   assign shamt = {27'b0, inst[24:20]};

   always_comb begin
      d      = '0;
      d.pc   = pc;
      ill    = 1'b0;
      unique case (1'b1)
         (opc == OPC_LUI): begin
            d.rd      = rd;
            d.imm     = imm_u(inst);
            d.alu_src = 1'b1;
            d.wb_sel  = WB_IMM;
         end
         (opc == OPC_AUIPC): begin
            d.rd      = rd;
            d.imm     = imm_u(inst);
            d.alu_op  = ALU_PCI;
            d.alu_src = 1'b1;
         end
         (opc == OPC_JAL): begin
            d.rd      = rd;
            d.imm     = imm_j(inst);
            d.alu_op  = ALU_PCI;
            d.alu_src = 1'b1;
            d.wb_sel  = WB_PC4;
            d.jump    = JMP_JAL;
         end
         (opc == OPC_JALR): begin
            ill       = (f3 != 3'b000);
            d.rd      = rd;
            d.rs1     = rs1;
            d.imm     = imm_i(inst);
            d.alu_src = 1'b1;
            d.wb_sel  = WB_PC4;
            d.jump    = JMP_JALR;
         end
         (opc == OPC_BRANCH): begin
            // ALU forms the target; the compare itself happens in EXU
            d.rs1     = rs1;
            d.rs2     = rs2;
            d.imm     = imm_b(inst);
            d.alu_op  = ALU_PCI;
            d.alu_src = 1'b1;
            unique case (f3)
               3'b000:  d.br_type = BR_BEQ;
               3'b001:  d.br_type = BR_BNE;
               3'b100:  d.br_type = BR_BLT;
               3'b101:  d.br_type = BR_BGE;
               3'b110:  d.br_type = BR_BLTU;
               3'b111:  d.br_type = BR_BGEU;
               default: ill = 1'b1;
            endcase
         end
         (opc == OPC_LOAD): begin
            ill       = (f3 == 3'b011) || (f3 == 3'b110) ||
                        (f3 == 3'b111);
            d.rd      = rd;
            d.rs1     = rs1;
            d.imm     = imm_i(inst);
            d.alu_src = 1'b1;
            d.mem_ren = 1'b1;
            d.mem_op  = mem_op_e'(f3);
            d.wb_sel  = WB_MEM;
         end
         (opc == OPC_STORE): begin
            ill       = (f3 > 3'b010);
            d.rs1     = rs1;
            d.rs2     = rs2;
            d.imm     = imm_s(inst);
            d.alu_src = 1'b1;
            d.mem_wen = 1'b1;
            d.mem_op  = mem_op_e'(f3);
         end
         (opc == OPC_OPIMM): begin
            d.rd      = rd;
            d.rs1     = rs1;
            d.imm     = imm_i(inst);
            d.alu_src = 1'b1;
            unique case (f3)
               3'b000: d.alu_op = ALU_ADD;
               3'b001: begin
                  d.alu_op = ALU_SLL;
                  d.imm    = shamt;
                  ill      = (f7 != F7_BASE);
               end
               3'b010: d.alu_op = ALU_SLT;
               3'b011: d.alu_op = ALU_SLTU;
               3'b100: d.alu_op = ALU_XOR;
               3'b101: begin
                  d.imm = shamt;
                  if (f7 == F7_BASE)
                     d.alu_op = ALU_SRL;
                  else if (f7 == F7_ALT)
                     d.alu_op = ALU_SRA;
                  else
                     ill = 1'b1;
               end
               3'b110: d.alu_op = ALU_OR;
               3'b111: d.alu_op = ALU_AND;
            endcase
         end
         (opc == OPC_OP): begin
            d.rd  = rd;
            d.rs1 = rs1;
            d.rs2 = rs2;
            if (f7 == F7_BASE) begin
               unique case (f3)
                  3'b000: d.alu_op = ALU_ADD;
                  3'b001: d.alu_op = ALU_SLL;
                  3'b010: d.alu_op = ALU_SLT;
                  3'b011: d.alu_op = ALU_SLTU;
                  3'b100: d.alu_op = ALU_XOR;
                  3'b101: d.alu_op = ALU_SRL;
                  3'b110: d.alu_op = ALU_OR;
                  3'b111: d.alu_op = ALU_AND;
               endcase
            end
            else if (f7 == F7_ALT && f3 == 3'b000)
               d.alu_op = ALU_SUB;
            else if (f7 == F7_ALT && f3 == 3'b101)
               d.alu_op = ALU_SRA;
`ifdef IDU_RV32M_EN
            else if (f7 == F7_MUL) begin
               d.mdu_en = 1'b1;
               d.mdu_op = f3;
            end
`endif
            else
               ill = 1'b1;
         end
         (opc == OPC_SYSTEM): begin
            unique case (f3)
               3'b000: begin
                  if (imm12 == 12'h000)
                     d.sys = SYS_ECALL;
                  else if (imm12 == 12'h001)
                     d.sys = SYS_EBREAK;
                  else if (imm12 == 12'h302)
                     d.sys = SYS_MRET;
                  else
                     ill = 1'b1;
               end
               3'b001, 3'b010: begin
                  d.rd       = rd;
                  d.rs1      = rs1;
                  d.wb_sel   = WB_CSR;
                  d.csr_addr = imm12;
                  d.csr_op   = (f3 == 3'b001) ? CSR_W : CSR_S;
               end
               default: ill = 1'b1;
            endcase
         end
         default: ill = 1'b1;
      endcase

      if (pc < PC_BASE)
         ill = 1'b1;

      // an illegal bundle carries only its pc and the trap code
      if (ill) begin
         d     = '0;
         d.pc  = pc;
         d.sys = SYS_ILL;
      end

      d.reg_wen = (d.rd != 5'd0);
   end

   assign dec = d;

endmodule

// File: rtl/ysyx_25030085_idu.sv
// Registered valid/ready decode stage with HALT state and accept counter.
// Define IDU_RV32M_EN to add the out_mdu_en/out_mdu_op ports and M decode.
module ysyx_25030085_idu
   import ysyx_25030085_pkg::*;
#(
   parameter int             XLEN    = XLEN_DEF,
   parameter logic [XLEN-1:0] PC_BASE = 32'h8000_0000,
   parameter int             CNT_W   = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [31:0]      in_inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic [XLEN-1:0]  out_imm,
   output logic [3:0]       out_alu_op,
   output logic             out_alu_src,
   output logic             out_mem_ren,
   output logic             out_mem_wen,
   output logic [2:0]       out_mem_op,
   output logic [2:0]       out_wb_sel,
   output logic             out_reg_wen,
   output logic [2:0]       out_br_type,
   output logic [1:0]       out_jump,
   output logic [1:0]       out_csr_op,
   output logic [11:0]      out_csr_addr,
   output logic [2:0]       out_sys,
`ifdef IDU_RV32M_EN
   output logic [2:0]       out_mdu_op,
   output logic             out_mdu_en,
`endif
   output logic             halted,
   output logic [CNT_W-1:0] dec_count
);

   idu_state_e       state;
   idu_state_e       state_n;
   id_ex_t           dec;
   id_ex_t           bun_q;
   logic             valid_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             stop_req;

   ysyx_25030085_idu_dec #(
      .PC_BASE (PC_BASE)
   ) u_dec (
      .pc   (in_pc),
      .inst (in_inst),
      .dec  (dec)
   );

   assign in_ready = (state == ST_RUN) &&
                     (!valid_q || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign stop_req = (dec.sys == SYS_EBREAK) ||
                     (dec.sys == SYS_ILL);

   always_ff @(posedge clock) begin
      if (reset)
         state <= ST_RUN;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         ST_RUN:  if (accept && stop_req) state_n = ST_HALT;
         ST_HALT: state_n = ST_HALT;
      endcase
   end

   // flush is ignored in HALT so the last bundle still drains
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         bun_q   <= '0;
         cnt_q   <= '0;
      end
      else if (flush && state == ST_RUN) begin
         valid_q <= 1'b0;
      end
      else if (accept) begin
         valid_q <= 1'b1;
         bun_q   <= dec;
         cnt_q   <= cnt_q + CNT_W'(1);
      end
      else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = bun_q.pc;
   assign out_rs1      = bun_q.rs1;
   assign out_rs2      = bun_q.rs2;
   assign out_rd       = bun_q.rd;
   assign out_imm      = bun_q.imm;
   assign out_alu_op   = bun_q.alu_op;
   assign out_alu_src  = bun_q.alu_src;
   assign out_mem_ren  = bun_q.mem_ren;
   assign out_mem_wen  = bun_q.mem_wen;
   assign out_mem_op   = bun_q.mem_op;
   assign out_wb_sel   = bun_q.wb_sel;
   assign out_reg_wen  = bun_q.reg_wen;
   assign out_br_type  = bun_q.br_type;
   assign out_jump     = bun_q.jump;
   assign out_csr_op   = bun_q.csr_op;
   assign out_csr_addr = bun_q.csr_addr;
   assign out_sys      = bun_q.sys;
`ifdef IDU_RV32M_EN
   assign out_mdu_op   = bun_q.mdu_op;
   assign out_mdu_en   = bun_q.mdu_en;
`endif
   assign halted       = (state == ST_HALT);
   assign dec_count    = cnt_q;

endmodule

// File: tb/tb_ysyx_25030085_idu.sv
// Bench for ysyx_25030085_idu: directed plan cases plus random traffic
// checked against a table-driven instruction model and handshake model.
module tb_ysyx_25030085_idu;

   logic        clock = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] in_pc, in_inst;
   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [3:0]  out_alu_op;
   logic        out_alu_src, out_mem_ren, out_mem_wen, out_reg_wen;
   logic [2:0]  out_mem_op, out_wb_sel, out_br_type, out_sys;
   logic [1:0]  out_jump, out_csr_op;
   logic [11:0] out_csr_addr;
`ifdef IDU_RV32M_EN
   logic [2:0]  out_mdu_op;
   logic        out_mdu_en;
`endif
   logic        halted;
   logic [31:0] dec_count;

   always #5 clock = ~clock;

   ysyx_25030085_idu dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_rd(out_rd), .out_imm(out_imm),
      .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
      .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
      .out_mem_op(out_mem_op), .out_wb_sel(out_wb_sel),
      .out_reg_wen(out_reg_wen), .out_br_type(out_br_type),
      .out_jump(out_jump), .out_csr_op(out_csr_op),
      .out_csr_addr(out_csr_addr), .out_sys(out_sys),
`ifdef IDU_RV32M_EN
      .out_mdu_op(out_mdu_op), .out_mdu_en(out_mdu_en),
`endif
      .halted(halted), .dec_count(dec_count)
   );

   typedef struct packed {
      logic [31:0] pc, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  alu;
      logic        src, ren, wen, rw, md_en;
      logic [2:0]  mop, wb, br, sys, md_op;
      logic [1:0]  jmp, csr;
      logic [11:0] caddr;
   } exp_t;

   typedef struct {
      logic [31:0] m, v;
      string       k;
      int          c;
   } row_t;

   row_t  tbl[$];
   int    total = 0, bad = 0;
   bit    m_valid = 0, m_halt = 0;
   logic [31:0] m_cnt = 0;
   exp_t  m_b = '0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic add(input logic [31:0] m, input logic [31:0] v,
                      input string k, input int c);
      row_t r;
      r.m = m; r.v = v; r.k = k; r.c = c;
      tbl.push_back(r);
   endtask

   // instruction lookup: first table row whose fixed bits match
   function automatic exp_t ref_dec(input logic [31:0] pc,
                                    input logic [31:0] i);
      exp_t e;
      int   hit = -1;
      logic [31:0] ii, si, bi, ui, ji;
      e = '0;
      e.pc = pc;
      foreach (tbl[n])
         if (hit < 0 && (i & tbl[n].m) == tbl[n].v) hit = n;
      if (hit < 0 || pc < 32'h8000_0000) begin
         e.sys = 3'd4;
         return e;
      end
      ii = {{20{i[31]}}, i[31:20]};
      si = {{20{i[31]}}, i[31:25], i[11:7]};
      bi = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      ui = {i[31:12], 12'b0};
      ji = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      case (tbl[hit].k)
         "lui":   begin e.rd = i[11:7]; e.imm = ui; e.src = 1; e.wb = 3; end
         "auipc": begin e.rd = i[11:7]; e.imm = ui; e.src = 1; e.alu = 9; end
         "jal":   begin e.rd = i[11:7]; e.imm = ji; e.src = 1; e.alu = 9;
                        e.wb = 2; e.jmp = 2'b01; end
         "jalr":  begin e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = ii;
                        e.src = 1; e.wb = 2; e.jmp = 2'b10; end
         "br":    begin e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm = bi;
                        e.src = 1; e.alu = 9; e.br = 3'(tbl[hit].c); end
         "ld":    begin e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = ii;
                        e.src = 1; e.ren = 1; e.wb = 1;
                        e.mop = 3'(tbl[hit].c); end
         "st":    begin e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm = si;
                        e.src = 1; e.wen = 1; e.mop = 3'(tbl[hit].c); end
         "opi":   begin e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = ii;
                        e.src = 1; e.alu = 4'(tbl[hit].c); end
         "sh":    begin e.rd = i[11:7]; e.rs1 = i[19:15];
                        e.imm = 32'(i[24:20]); e.src = 1;
                        e.alu = 4'(tbl[hit].c); end
         "op":    begin e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
                        e.alu = 4'(tbl[hit].c); end
         "mul":   begin e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
                        e.md_en = 1; e.md_op = i[14:12]; end
         "csr":   begin e.rd = i[11:7]; e.rs1 = i[19:15]; e.wb = 4;
                        e.caddr = i[31:20]; e.csr = 2'(tbl[hit].c); end
         "sys":   e.sys = 3'(tbl[hit].c);
         default: e.sys = 3'd4;
      endcase
      e.rw = (e.rd != 5'd0);
      return e;
   endfunction

   task automatic chk_out();
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("halted", 32'(halted), 32'(m_halt));
      check("dec_count", dec_count, m_cnt);
      check("pc", out_pc, m_b.pc);
      check("rs1", 32'(out_rs1), 32'(m_b.rs1));
      check("rs2", 32'(out_rs2), 32'(m_b.rs2));
      check("rd", 32'(out_rd), 32'(m_b.rd));
      check("imm", out_imm, m_b.imm);
      check("alu_op", 32'(out_alu_op), 32'(m_b.alu));
      check("alu_src", 32'(out_alu_src), 32'(m_b.src));
      check("mem_ren", 32'(out_mem_ren), 32'(m_b.ren));
      check("mem_wen", 32'(out_mem_wen), 32'(m_b.wen));
      check("mem_op", 32'(out_mem_op), 32'(m_b.mop));
      check("wb_sel", 32'(out_wb_sel), 32'(m_b.wb));
      check("reg_wen", 32'(out_reg_wen), 32'(m_b.rw));
      check("br_type", 32'(out_br_type), 32'(m_b.br));
      check("jump", 32'(out_jump), 32'(m_b.jmp));
      check("csr_op", 32'(out_csr_op), 32'(m_b.csr));
      check("csr_addr", 32'(out_csr_addr), 32'(m_b.caddr));
      check("sys", 32'(out_sys), 32'(m_b.sys));
`ifdef IDU_RV32M_EN
      check("mdu_en", 32'(out_mdu_en), 32'(m_b.md_en));
      check("mdu_op", 32'(out_mdu_op), 32'(m_b.md_op));
`endif
   endtask

   // one clock: drive, check in_ready, advance model at the edge, check
   task automatic cyc(input bit v, input logic [31:0] pc,
                      input logic [31:0] inst, input bit rdy,
                      input bit fl, input bit rst);
      bit   er;
      exp_t d;
      in_valid = v; in_pc = pc; in_inst = inst;
      out_ready = rdy; flush = fl; reset = rst;
      #1;
      er = !m_halt && (!m_valid || rdy) && !fl;
      if (!rst) check("in_ready", 32'(in_ready), 32'(er));
      @(posedge clock);
      if (rst) begin
         m_valid = 0; m_halt = 0; m_cnt = 0; m_b = '0;
      end
      else if (fl && !m_halt) begin
         m_valid = 0;
      end
      else if (v && er) begin
         d = ref_dec(pc, inst);
         m_valid = 1; m_b = d; m_cnt = m_cnt + 1;
         if (d.sys == 3'd2 || d.sys == 3'd4) m_halt = 1;
      end
      else if (rdy) begin
         m_valid = 0;
      end
      #1;
      chk_out();
   endtask

   localparam logic [31:0] ADDI = 32'h00500093;

   initial begin
      add(32'h7f, 32'h37, "lui", 0);
      add(32'h7f, 32'h17, "auipc", 0);
      add(32'h7f, 32'h6f, "jal", 0);
      add(32'h707f, 32'h67, "jalr", 0);
      add(32'h707f, 32'h0063, "br", 1);
      add(32'h707f, 32'h1063, "br", 2);
      add(32'h707f, 32'h4063, "br", 3);
      add(32'h707f, 32'h5063, "br", 4);
      add(32'h707f, 32'h6063, "br", 5);
      add(32'h707f, 32'h7063, "br", 6);
      add(32'h707f, 32'h0003, "ld", 0);
      add(32'h707f, 32'h1003, "ld", 1);
      add(32'h707f, 32'h2003, "ld", 2);
      add(32'h707f, 32'h4003, "ld", 4);
      add(32'h707f, 32'h5003, "ld", 5);
      add(32'h707f, 32'h0023, "st", 0);
      add(32'h707f, 32'h1023, "st", 1);
      add(32'h707f, 32'h2023, "st", 2);
      add(32'h707f, 32'h0013, "opi", 0);
      add(32'h707f, 32'h2013, "opi", 2);
      add(32'h707f, 32'h3013, "opi", 3);
      add(32'h707f, 32'h4013, "opi", 4);
      add(32'h707f, 32'h6013, "opi", 7);
      add(32'h707f, 32'h7013, "opi", 8);
      add(32'hfe00707f, 32'h00001013, "sh", 1);
      add(32'hfe00707f, 32'h00005013, "sh", 6);
      add(32'hfe00707f, 32'h40005013, "sh", 5);
      add(32'hfe00707f, 32'h00000033, "op", 0);
      add(32'hfe00707f, 32'h40000033, "op", 10);
      add(32'hfe00707f, 32'h00001033, "op", 1);
      add(32'hfe00707f, 32'h00002033, "op", 2);
      add(32'hfe00707f, 32'h00003033, "op", 3);
      add(32'hfe00707f, 32'h00004033, "op", 4);
      add(32'hfe00707f, 32'h00005033, "op", 6);
      add(32'hfe00707f, 32'h40005033, "op", 5);
      add(32'hfe00707f, 32'h00006033, "op", 7);
      add(32'hfe00707f, 32'h00007033, "op", 8);
`ifdef IDU_RV32M_EN
      for (int f = 0; f < 8; f++)
         add(32'hfe00707f, 32'h02000033 | (f << 12), "mul", 0);
`endif
      add(32'hfff0707f, 32'h00000073, "sys", 1);
      add(32'hfff0707f, 32'h00100073, "sys", 2);
      add(32'hfff0707f, 32'h30200073, "sys", 3);
      add(32'h707f, 32'h1073, "csr", 1);
      add(32'h707f, 32'h2073, "csr", 2);

      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_cnt", dec_count, 0);

      cyc(1, 32'h80000000, ADDI, 1, 0, 0);
      check("addi_valid", 32'(out_valid), 1);
      check("addi_rd", 32'(out_rd), 1);
      check("addi_imm", out_imm, 5);
      check("addi_src", 32'(out_alu_src), 1);
      check("addi_wen", 32'(out_reg_wen), 1);
      check("addi_cnt", dec_count, 1);

      cyc(1, 32'h80000004, 32'h0000a103, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(1, 32'h80000008, 32'h0020a023, 0, 0, 0);
         check("lw_hold_ren", 32'(out_mem_ren), 1);
         check("lw_hold_op", 32'(out_mem_op), 2);
      end
      cyc(1, 32'h80000008, 32'h0020a023, 1, 0, 0);
      check("sw_wen", 32'(out_mem_wen), 1);
      check("sw_ren", 32'(out_mem_ren), 0);
      check("sw_op", 32'(out_mem_op), 2);

      cyc(1, 32'h8000000c, 32'h00208463, 1, 0, 0);
      check("beq_br", 32'(out_br_type), 1);
      check("beq_imm", out_imm, 8);
      check("beq_wen", 32'(out_reg_wen), 0);
      cyc(1, 32'h80000010, 32'h008000ef, 1, 0, 0);
      check("jal_jump", 32'(out_jump), 1);
      check("jal_wb", 32'(out_wb_sel), 2);
      check("jal_imm", out_imm, 8);

      cyc(1, 32'h80000014, ADDI, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      check("flush_valid", 32'(out_valid), 0);

      cyc(1, 32'h80000018, 32'h00100073, 1, 0, 0);
      check("ebrk_sys", 32'(out_sys), 2);
      check("ebrk_halt", 32'(halted), 1);
      for (int k = 0; k < 3; k++)
         cyc(1, 32'h8000001c, ADDI, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 1);
      check("rst_halt", 32'(halted), 0);

      cyc(1, 32'h80000100, 32'hffffffff, 1, 0, 0);
      check("ill_sys", 32'(out_sys), 4);
      check("ill_mwen", 32'(out_mem_wen), 0);
      cyc(1, 32'h80000104, ADDI, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 1);
      cyc(1, 32'h7ffffffc, ADDI, 1, 0, 0);
      check("lowpc_sys", 32'(out_sys), 4);
      check("lowpc_wen", 32'(out_reg_wen), 0);
      cyc(0, 0, 0, 1, 0, 1);

      for (int n = 0; n < 4000; n++) begin
         bit v, r, f, rs;
         logic [31:0] pc, inst;
         row_t row;
         v  = ($urandom_range(0, 9) < 7);
         r  = ($urandom_range(0, 9) < 7);
         f  = ($urandom_range(0, 19) == 0);
         rs = (m_halt && $urandom_range(0, 3) == 0) ||
              ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 49) == 0)
            pc = $urandom & 32'h7fff_fffc;
         else
            pc = 32'h8000_0000 | ($urandom & 32'h0fff_fffc);
         row = tbl[$urandom_range(0, tbl.size() - 1)];
         inst = ($urandom & ~row.m) | row.v;
         if ($urandom_range(0, 19) == 0) inst = $urandom;
         cyc(v, pc, inst, r, f, rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_25030085_idu.md
Name: ysyx_25030085_idu

Overview:
Registered, handshaked instruction-decode stage for the RV32 core. Accepts {pc, inst} from IFU over valid/ready and produces a one-entry registered control bundle for EXU/LSU/WBU. Unlike the combinational decoder, branch resolution moves to EXU and traps are reported as a code, not via DPI. A HALT state stops the pipeline after ebreak/illegal, and an accepted-instruction counter is kept.

Parameters:
XLEN, 32, datapath/imm/pc width (32 only legal value today, kept for RV64 growth)
PC_BASE, 32'h8000_0000, lowest legal fetch address; inst with pc < PC_BASE decodes as illegal
CNT_W, 32, width of decoded-instruction counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
flush  in  1  squash held output (EXU redirect)
in_valid  in  1  IFU offers instruction
in_ready  out  1  IDU can accept
in_pc  in  XLEN  instruction pc
in_inst  in  32  instruction word
out_valid  out  1  bundle valid
out_ready  in  1  EXU accepts bundle
out_pc  out  XLEN  pc of bundle
out_rs1/out_rs2/out_rd  out  5 each  register indices (0 when unused)
out_imm  out  XLEN  selected immediate (I/S/B/U/J; shamt zero-extended)
out_alu_op  out  4  0 add,1 sll,2 slt,3 sltu,4 xor,5 sra,6 srl,7 or,8 and,9 pc+imm,A sub
out_alu_src  out  1  0 rs2, 1 imm
out_mem_ren/out_mem_wen  out  1 each  load/store
out_mem_op  out  3  0 b,1 h,2 w,4 bu,5 hu
out_wb_sel  out  3  0 alu,1 mem,2 pc+4,3 imm,4 csr
out_reg_wen  out  1  rd write (forced 0 when rd==0)
out_br_type  out  3  0 none,1 beq,2 bne,3 blt,4 bge,5 bltu,6 bgeu
out_jump  out  2  01 jal, 10 jalr
out_csr_op  out  2  0 none,1 write,2 set
out_csr_addr  out  12  inst[31:20]
out_sys  out  3  0 none,1 ecall,2 ebreak,3 mret,4 illegal
halted  out  1  IDU in HALT
dec_count  out  CNT_W  accepted instructions

Behaviour:
- Reset: state RUN; out_valid=0; all out_* bundle fields 0; halted=0; dec_count=0.
- in_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
- Accept (in_valid && in_ready): decoded bundle registered, out_valid=1 next cycle; latency 1 cycle; dec_count += 1 (wraps at 2^CNT_W).
- out_valid && !out_ready: bundle held stable; no accept.
- out_valid && out_ready && in_valid: back-to-back, full throughput, out_valid stays 1.
- flush: next cycle out_valid=0; highest priority over accept/hold; counter not incremented; no effect in HALT.
- Illegal: unknown opcode, bad funct3/funct7 combos, SYSTEM funct3 not in {000,001,010}, SYSTEM funct3=000 with imm not 0/1/0x302, or pc<PC_BASE. Bundle is emitted with out_sys=4, reg_wen/mem_wen/mem_ren/csr_op=0.
- ebreak/illegal accepted: bundle still emitted; state -> HALT the following cycle; halted=1; in_ready=0; output drains normally. Only reset leaves HALT.
- ecall/mret: out_sys code only; state stays RUN.
- csrrw/csrrs: wb_sel=4, reg_wen=(rd!=0), csr_op set.
- Reset mid-handshake: held bundle discarded, out_valid=0 same edge.

Optional Feature:
IDU_RV32M_EN: when defined, opcode 0110011 with funct7=0000001 decodes mul/mulh/mulhsu/mulhu/div/divu/rem/remu; adds port out_mdu_op (3 bits = funct3) and out_mdu_en. alu_op=0 for these. When undefined, these ports are absent and that encoding is illegal.

Decomposition:
- Package ysyx_25030085_pkg: opcode constants, alu_op/mem_op/wb_sel/br_type/sys/csr_op encodings, XLEN default.
- Sub-module ysyx_25030085_idu_dec: pure combinational inst+pc -> bundle. The top holds the handshake register, state FSM and counter.

Test Plan:
- addi x1,x0,5 (0x00500093) @pc 0x80000000, out_ready=1 -> next cycle out_valid=1, rd=1, imm=5, alu_op=0, alu_src=1, reg_wen=1, dec_count=1.
- Back-to-back lw 0x0000a103 then sw 0x0020a023 with out_ready low for 3 cycles after first accept -> first bundle held stable, in_ready=0, second accepted on release; mem_op=2 both; wen/ren correct.
- beq 0x00208463 -> br_type=1, imm=8, reg_wen=0; jal 0x008000ef -> jump=01, wb_sel=2, imm=8.
- ebreak 0x00100073 followed by in_valid stream -> out_sys=2 emitted, halted=1 next cycle, no further accepts, count frozen; reset -> RUN.
- inst 0xffffffff and addi at pc 0x7ffffffc -> out_sys=4, all write enables 0, HALT entered.
- flush asserted while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, in_ready=0 during flush cycle, count unchanged.
